// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-client arbiter in front of the single-port data memory. Each client
// has a one-deep holding register, so it can have one request outstanding.
// Port 0 is instruction fetch and only reads. Port 1 is load/store and
// can read or write.
//
// When the memory is idle, one pending request is granted. Ties are broken
// round-robin. The grant issues a single-cycle memory request pulse, then
// the arbiter waits for the memory ack. When the ack arrives, the arbiter
// returns a one-cycle ack, plus read data for reads, to the granted client.
//
// Ports
//   clk, rst                    clock; asynchronous active-low reset
//   p0_rd_req, p0_addr          fetch read request pulse and byte address
//   p0_busy                     port-0 holding register occupied
//   p0_ack, p0_rd_data          port-0 completion pulse and read data
//   p1_rd_req, p1_wr_req        load / store request pulses
//   p1_addr, p1_wr_data         port-1 byte address and store data
//   p1_busy                     port-1 holding register occupied
//   p1_ack, p1_rd_data          port-1 completion pulse and read data
//                               (p1_rd_data is untouched by store acks)
//   mem_rd_req, mem_wr_req      single-cycle memory request pulses
//   mem_addr, mem_wr_data       memory address and data, held after the pulse
//   mem_busy                    memory cannot accept a request
//   mem_ack, mem_rd_data        memory completion pulse and read data
//   proto_err                   sticky: dropped request or p1 rd+wr together
//   timeout_err                 sticky: WAIT lasted TIMEOUT cycles without ack
//
// State table
//   S_IDLE | no memory transaction outstanding; grant when a port is pending
//   S_WAIT | one memory request issued; waiting for mem_ack
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_rd_req,
    input  logic [31:0] p0_addr,
    output logic        p0_busy,
    output logic        p0_ack,
    output logic [31:0] p0_rd_data,

    input  logic        p1_rd_req,
    input  logic        p1_wr_req,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wr_data,
    output logic        p1_busy,
    output logic        p1_ack,
    output logic [31:0] p1_rd_data,

    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic        mem_busy,
    input  logic        mem_ack,
    input  logic [31:0] mem_rd_data,

    output logic        proto_err,
    output logic        timeout_err
);

    localparam int            CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_PRELIM = CW'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    // Holding registers. Port 0 never writes, so it carries no is_wr or data.
    logic          r_p0_pend;
    logic [31:0]   r_p0_addr;
    logic          r_p1_pend;
    logic          r_p1_wr;
    logic [31:0]   r_p1_addr;
    logic [31:0]   r_p1_wdata;

    // Grant bookkeeping
    logic          r_last_grant;
    logic          r_gnt_port;
    logic          r_gnt_wr;
    logic [CW-1:0] r_cnt;

    // Registered outputs
    logic          r_mem_rd_req;
    logic          r_mem_wr_req;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wr_data;
    logic          r_p0_ack;
    logic [31:0]   r_p0_rd_data;
    logic          r_p1_ack;
    logic [31:0]   r_p1_rd_data;
    logic          r_proto_err;
    logic          r_timeout_err;

    // Combinational helpers
    logic          w_p0_cap;
    logic          w_p1_any;
    logic          w_p1_cap;
    logic          w_proto_hit;
    logic          w_grant_go;
    logic          w_done;
    logic          w_sel;
    logic          w_sel_wr;
    logic [31:0]   w_sel_addr;
    logic [31:0]   w_sel_wdata;

    // ------------------------------------------------------------------
    // Request capture and protocol checking
    // ------------------------------------------------------------------
    assign w_p0_cap = p0_rd_req & ~r_p0_pend;
    assign w_p1_any = p1_rd_req | p1_wr_req;
    assign w_p1_cap = w_p1_any & ~r_p1_pend;

    // A pulse that hits an occupied holding register is lost, as is the read
    // half of a simultaneous p1 read+write. Both are reported.
    assign w_proto_hit = (p0_rd_req & r_p0_pend)
                       | (w_p1_any & r_p1_pend)
                       | (p1_rd_req & p1_wr_req);

    // ------------------------------------------------------------------
    // Grant selection: alternate on a tie, otherwise take whoever is pending
    // ------------------------------------------------------------------
    always_comb begin
        w_sel       = 1'b0;
        w_sel_wr    = 1'b0;
        w_sel_addr  = r_p0_addr;
        w_sel_wdata = '0;
        if (r_p0_pend && r_p1_pend) begin
            w_sel = ~r_last_grant;
        end else begin
            w_sel = r_p1_pend;
        end
        if (w_sel) begin
            w_sel_wr    = r_p1_wr;
            w_sel_addr  = r_p1_addr;
            w_sel_wdata = r_p1_wdata;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_go  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A mem_ack seen here is a leftover from a transaction that
                // a reset discarded, so it is ignored.
                if ((r_p0_pend || r_p1_pend) && !mem_busy) begin
                    w_grant_go  = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holding registers. A port can only be completed while it is pending,
    // and it can only capture while it is not, so the two never collide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p0_pend <= 1'b0;
            r_p0_addr <= '0;
        end else if (w_p0_cap) begin
            r_p0_pend <= 1'b1;
            r_p0_addr <= p0_addr;
        end else if (w_done && !r_gnt_port) begin
            r_p0_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p1_pend  <= 1'b0;
            r_p1_wr    <= 1'b0;
            r_p1_addr  <= '0;
            r_p1_wdata <= '0;
        end else if (w_p1_cap) begin
            r_p1_pend <= 1'b1;
            r_p1_wr   <= p1_wr_req;   // rd+wr together resolves to a write
            r_p1_addr <= p1_addr;
            if (p1_wr_req) begin
                r_p1_wdata <= p1_wr_data;
            end
        end else if (w_done && r_gnt_port) begin
            r_p1_pend <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Memory-side request registers. The pulse lasts one cycle because
    // w_grant_go only fires in IDLE and the next cycle is always WAIT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_rd_req  <= 1'b0;
            r_mem_wr_req  <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_gnt_port    <= 1'b0;
            r_gnt_wr      <= 1'b0;
        end else begin
            r_mem_rd_req <= w_grant_go & ~w_sel_wr;
            r_mem_wr_req <= w_grant_go &  w_sel_wr;
            if (w_grant_go) begin
                r_mem_addr    <= w_sel_addr;
                r_mem_wr_data <= w_sel_wdata;
                r_gnt_port    <= w_sel;
                r_gnt_wr      <= w_sel_wr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Completion: client ack, read data capture, round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p0_ack     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p0_rd_data <= '0;
            r_p1_rd_data <= '0;
            r_last_grant <= 1'b1;
        end else begin
            r_p0_ack <= w_done & ~r_gnt_port;
            r_p1_ack <= w_done &  r_gnt_port;
            if (w_done) begin
                r_last_grant <= r_gnt_port;
                if (!r_gnt_port) begin
                    r_p0_rd_data <= mem_rd_data;
                end else if (!r_gnt_wr) begin
                    r_p1_rd_data <= mem_rd_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // WAIT-cycle counter. It saturates at TIMEOUT, and it only flags: the
    // outstanding transaction is still completed whenever the ack arrives.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else if (w_grant_go) begin
            r_cnt <= '0;
        end else if ((r_state == S_WAIT) && !mem_ack && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_PRELIM) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_proto_err <= 1'b0;
        end else if (w_proto_hit) begin
            r_proto_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign p0_busy     = r_p0_pend;
    assign p0_ack      = r_p0_ack;
    assign p0_rd_data  = r_p0_rd_data;
    assign p1_busy     = r_p1_pend;
    assign p1_ack      = r_p1_ack;
    assign p1_rd_data  = r_p1_rd_data;
    assign mem_rd_req  = r_mem_rd_req;
    assign mem_wr_req  = r_mem_wr_req;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_wr_data;
    assign proto_err   = r_proto_err;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_rd_req;
    logic [31:0] p0_addr;
    logic        p0_busy;
    logic        p0_ack;
    logic [31:0] p0_rd_data;
    logic        p1_rd_req;
    logic        p1_wr_req;
    logic [31:0] p1_addr;
    logic [31:0] p1_wr_data;
    logic        p1_busy;
    logic        p1_ack;
    logic [31:0] p1_rd_data;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_busy;
    logic        mem_ack;
    logic [31:0] mem_rd_data;
    logic        proto_err;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    // memory model state
    logic [31:0] mem [0:1023];
    int          ack_delay = 6;
    int          mm_cnt    = 0;
    logic [31:0] mm_addr   = '0;
    logic [31:0] mm_wdata  = '0;
    logic        mm_wr     = 1'b0;
    int          overlap   = 0;

    mem_arbiter #(.TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .p0_rd_req   (p0_rd_req),
        .p0_addr     (p0_addr),
        .p0_busy     (p0_busy),
        .p0_ack      (p0_ack),
        .p0_rd_data  (p0_rd_data),
        .p1_rd_req   (p1_rd_req),
        .p1_wr_req   (p1_wr_req),
        .p1_addr     (p1_addr),
        .p1_wr_data  (p1_wr_data),
        .p1_busy     (p1_busy),
        .p1_ack      (p1_ack),
        .p1_rd_data  (p1_rd_data),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_busy    (mem_busy),
        .mem_ack     (mem_ack),
        .mem_rd_data (mem_rd_data),
        .proto_err   (proto_err),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: ack arrives ack_delay cycles after the request cycle.
    initial begin
        mem_ack     = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mm_cnt > 0) begin
                mm_cnt--;
                if (mm_cnt == 0) begin
                    mem_ack = 1'b1;
                    if (mm_wr) mem[mm_addr[11:2]] = mm_wdata;
                    else       mem_rd_data = mem[mm_addr[11:2]];
                end
            end
            if (mem_rd_req === 1'b1 || mem_wr_req === 1'b1) begin
                if (mm_cnt > 0 || (mem_rd_req === 1'b1 && mem_wr_req === 1'b1)) overlap++;
                mm_cnt   = ack_delay;
                mm_addr  = mem_addr;
                mm_wr    = mem_wr_req;
                mm_wdata = mem_wr_data;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [199:0] outs;
        #2 rst = 1'b0;
        tick();
        tick();
        outs = {p0_busy, p0_ack, p0_rd_data, p1_busy, p1_ack, p1_rd_data,
                mem_rd_req, mem_wr_req, mem_addr, mem_wr_data, proto_err, timeout_err};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
        rst = 1'b1;
        tick();
        total++;
        if ({p0_busy, p1_busy, mem_rd_req, mem_wr_req} !== 4'b0000) begin
            bad++; $display("FAIL reset_release: got %b want 0000", {p0_busy, p1_busy, mem_rd_req, mem_wr_req});
        end
    endtask

    task automatic test_read_latency();
        tick(); p0_addr = 32'h10; p0_rd_req = 1'b1;               // c
        tick(); p0_rd_req = 1'b0;                                 // c+1
        total++;
        if (p0_busy !== 1'b1) begin bad++; $display("FAIL lat_busy: got %b want 1", p0_busy); end
        total++;
        if (mem_rd_req !== 1'b0) begin bad++; $display("FAIL lat_early_req: got %b want 0", mem_rd_req); end
        tick();                                                   // c+2
        total++;
        if ({mem_rd_req, mem_wr_req} !== 2'b10) begin bad++; $display("FAIL lat_req: got %b want 10", {mem_rd_req, mem_wr_req}); end
        total++;
        if (mem_addr !== 32'h10) begin bad++; $display("FAIL lat_addr: got %h want 00000010", mem_addr); end
        for (int k = 3; k <= 8; k++) begin
            tick();
            total++;
            if (p0_ack !== 1'b0 || mem_rd_req !== 1'b0) begin
                bad++; $display("FAIL lat_quiet c+%0d: got ack=%b req=%b want 0 0", k, p0_ack, mem_rd_req);
            end
        end
        tick();                                                   // c+9
        total++;
        if (p0_ack !== 1'b1) begin bad++; $display("FAIL lat_ack: got %b want 1", p0_ack); end
        total++;
        if (p0_rd_data !== 32'hCAFEF00D) begin bad++; $display("FAIL lat_data: got %h want cafef00d", p0_rd_data); end
        total++;
        if (p0_busy !== 1'b0) begin bad++; $display("FAIL lat_busy_clr: got %b want 0", p0_busy); end
        tick();                                                   // c+10
        total++;
        if (p0_ack !== 1'b0 || p0_rd_data !== 32'hCAFEF00D) begin
            bad++; $display("FAIL lat_hold: got ack=%b data=%h want 0 cafef00d", p0_ack, p0_rd_data);
        end
    endtask

    task automatic test_write_then_read();
        bit got;
        bit seen_wr;
        logic [31:0] wa, wd;
        tick(); p1_addr = 32'h30; p1_rd_req = 1'b1;
        tick(); p1_rd_req = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin tick(); if (p1_ack === 1'b1) got = 1; end
        total++;
        if (!got) begin bad++; $display("FAIL wr_pre_ack: got none want ack"); end
        total++;
        if (p1_rd_data !== 32'h1000000C) begin bad++; $display("FAIL wr_pre_data: got %h want 1000000c", p1_rd_data); end

        tick(); p1_addr = 32'h20; p1_wr_data = 32'h12345678; p1_wr_req = 1'b1;
        tick(); p1_wr_req = 1'b0;
        got = 0; seen_wr = 0; wa = '0; wd = '0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (mem_wr_req === 1'b1) begin seen_wr = 1; wa = mem_addr; wd = mem_wr_data; end
            if (p1_ack === 1'b1) got = 1;
        end
        total++;
        if (!got) begin bad++; $display("FAIL wr_ack: got none want ack"); end
        total++;
        if (!seen_wr || wa !== 32'h20 || wd !== 32'h12345678) begin
            bad++; $display("FAIL wr_mem_req: got seen=%0d addr=%h data=%h want 1 00000020 12345678", seen_wr, wa, wd);
        end
        total++;
        if (p1_rd_data !== 32'h1000000C) begin bad++; $display("FAIL wr_rd_data_kept: got %h want 1000000c", p1_rd_data); end

        // next request in the ack cycle
        p1_addr = 32'h20; p1_rd_req = 1'b1;
        tick(); p1_rd_req = 1'b0;
        total++;
        if (p1_busy !== 1'b1) begin bad++; $display("FAIL rd_in_ack_cycle: got busy=%b want 1", p1_busy); end
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin tick(); if (p1_ack === 1'b1) got = 1; end
        total++;
        if (!got || p1_rd_data !== 32'h12345678) begin
            bad++; $display("FAIL rd_after_wr: got ack=%0d data=%h want 1 12345678", got, p1_rd_data);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] order [0:7];
        logic [31:0] exp_a;
        int n = 0;
        bit g0, g1;
        for (int i = 0; i < 3; i++) begin
            tick();
            p0_addr = 32'h100 + 32'(i * 8); p1_addr = 32'h104 + 32'(i * 8);
            p0_rd_req = 1'b1; p1_rd_req = 1'b1;
            tick(); p0_rd_req = 1'b0; p1_rd_req = 1'b0;
            g0 = 0; g1 = 0;
            for (int k = 0; k < 40 && !(g0 && g1); k++) begin
                tick();
                if ((mem_rd_req === 1'b1 || mem_wr_req === 1'b1) && n < 8) begin order[n] = mem_addr; n++; end
                if (p0_ack === 1'b1) begin
                    g0 = 1;
                    total++;
                    if (p0_rd_data !== 32'h10000040 + 32'(2 * i)) begin
                        bad++; $display("FAIL rr_p0_data %0d: got %h want %h", i, p0_rd_data, 32'h10000040 + 32'(2 * i));
                    end
                end
                if (p1_ack === 1'b1) begin
                    g1 = 1;
                    total++;
                    if (p1_rd_data !== 32'h10000041 + 32'(2 * i)) begin
                        bad++; $display("FAIL rr_p1_data %0d: got %h want %h", i, p1_rd_data, 32'h10000041 + 32'(2 * i));
                    end
                end
            end
            total++;
            if (!(g0 && g1)) begin bad++; $display("FAIL rr_acks %0d: got p0=%0d p1=%0d want 1 1", i, g0, g1); end
        end
        total++;
        if (n !== 6) begin bad++; $display("FAIL rr_count: got %0d want 6", n); end
        for (int j = 0; j < 6 && j < n; j++) begin
            exp_a = ((j % 2) == 0) ? 32'h100 + 32'((j / 2) * 8) : 32'h104 + 32'((j / 2) * 8);
            total++;
            if (order[j] !== exp_a) begin bad++; $display("FAIL rr_order %0d: got %h want %h", j, order[j], exp_a); end
        end
        total++;
        if (overlap !== 0) begin bad++; $display("FAIL rr_overlap: got %0d want 0", overlap); end
    endtask

    task automatic test_proto_err();
        int acks = 0;
        total++;
        if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_initial: got %b want 0", proto_err); end
        tick(); p0_addr = 32'h10; p0_rd_req = 1'b1;               // c
        tick(); p0_rd_req = 1'b0;                                 // c+1
        tick(); p0_addr = 32'h40; p0_rd_req = 1'b1;               // c+2, port busy
        tick(); p0_rd_req = 1'b0;                                 // c+3
        total++;
        if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_set: got %b want 1", proto_err); end
        for (int k = 0; k < 25; k++) begin
            tick();
            if (p0_ack === 1'b1) begin
                acks++;
                total++;
                if (p0_rd_data !== 32'hCAFEF00D) begin bad++; $display("FAIL proto_data: got %h want cafef00d", p0_rd_data); end
            end
        end
        total++;
        if (acks !== 1) begin bad++; $display("FAIL proto_ack_count: got %0d want 1", acks); end
        total++;
        if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_sticky: got %b want 1", proto_err); end
    endtask

    task automatic test_timeout();
        int ack_k = -1;
        ack_delay = 70;
        tick(); p0_addr = 32'h14; p0_rd_req = 1'b1;
        tick(); p0_rd_req = 1'b0;
        tick();                                                   // r = c+2
        total++;
        if (mem_rd_req !== 1'b1) begin bad++; $display("FAIL to_req: got %b want 1", mem_rd_req); end
        for (int k = 1; k <= 80 && ack_k < 0; k++) begin
            tick();                                               // r+k
            if (k == 60) begin
                total++;
                if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", timeout_err); end
            end
            if (k == 66) begin
                total++;
                if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_set: got %b want 1", timeout_err); end
            end
            if (p0_ack === 1'b1) ack_k = k;
        end
        total++;
        if (ack_k !== 71) begin bad++; $display("FAIL to_late_ack: got r+%0d want r+71", ack_k); end
        total++;
        if (p0_rd_data !== 32'h10000005 || timeout_err !== 1'b1) begin
            bad++; $display("FAIL to_complete: got data=%h err=%b want 10000005 1", p0_rd_data, timeout_err);
        end
        ack_delay = 6;
    endtask

    task automatic test_reset_mid();
        logic [199:0] outs;
        int acks = 0;
        int ack_c = -1;
        bit got;
        tick(); p0_addr = 32'h10; p0_rd_req = 1'b1;               // c
        tick(); p0_rd_req = 1'b0;
        tick();                                                   // c+2 mem req
        tick();
        tick();                                                   // c+4, in WAIT
        rst = 1'b0;
        #1;
        outs = {p0_busy, p0_ack, p0_rd_data, p1_busy, p1_ack, p1_rd_data,
                mem_rd_req, mem_wr_req, mem_addr, mem_wr_data, proto_err, timeout_err};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL rstmid_outputs: got %h want 0", outs); end
        tick();
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (p0_ack === 1'b1 || p1_ack === 1'b1) acks++;
        end
        total++;
        if (acks !== 0 || p0_busy !== 1'b0 || p0_rd_data !== 32'h0) begin
            bad++; $display("FAIL rstmid_no_ack: got acks=%0d busy=%b data=%h want 0 0 0", acks, p0_busy, p0_rd_data);
        end

        // read+write together: treated as a write, flagged
        tick(); p1_addr = 32'h50; p1_wr_data = 32'hDEADBEEF; p1_rd_req = 1'b1; p1_wr_req = 1'b1;
        tick(); p1_rd_req = 1'b0; p1_wr_req = 1'b0;
        total++;
        if (proto_err !== 1'b1) begin bad++; $display("FAIL rdwr_proto: got %b want 1", proto_err); end
        tick();
        total++;
        if ({mem_rd_req, mem_wr_req} !== 2'b01 || mem_wr_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rdwr_as_write: got req=%b data=%h want 01 deadbeef", {mem_rd_req, mem_wr_req}, mem_wr_data);
        end
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin tick(); if (p1_ack === 1'b1) got = 1; end
        total++;
        if (!got || p1_rd_data !== 32'h0) begin
            bad++; $display("FAIL rdwr_ack: got ack=%0d data=%h want 1 00000000", got, p1_rd_data);
        end

        // fresh request served normally
        tick(); p0_addr = 32'h50; p0_rd_req = 1'b1;               // c
        tick(); p0_rd_req = 1'b0;                                 // c+1
        for (int k = 2; k <= 20 && ack_c < 0; k++) begin
            tick();
            if (p0_ack === 1'b1) ack_c = k;
        end
        total++;
        if (ack_c !== 9 || p0_rd_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rstmid_fresh: got c+%0d data=%h want c+9 deadbeef", ack_c, p0_rd_data);
        end
    endtask

    initial begin
        rst        = 1'b1;
        p0_rd_req  = 1'b0;
        p0_addr    = '0;
        p1_rd_req  = 1'b0;
        p1_wr_req  = 1'b0;
        p1_addr    = '0;
        p1_wr_data = '0;
        mem_busy   = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h10000000 + 32'(i);
        mem[4] = 32'hCAFEF00D;

        test_reset();
        test_read_latency();
        test_write_then_read();
        test_round_robin();
        test_proto_err();
        test_timeout();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory request arbiter sitting directly upstream of the delayed single-port data memory. It buffers one outstanding request per client, from the instruction-fetch port (port 0, read-only) and the load/store port (port 1, read/write). It grants round-robin, drives the memory's single-cycle request pulse and waits for the memory's ack pulse. It then returns a one-cycle ack with read data to the granted client.

## Interface
- TIMEOUT, 64: cycles in WAIT without mem_ack before timeout_err sets; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low; one clock, no other reset
- p0_rd_req  in  1  fetch read request, single-cycle pulse
- p0_addr  in  32  fetch byte address, sampled with p0_rd_req
- p0_busy  out  1  port 0 holding register occupied
- p0_ack  out  1  one-cycle completion pulse
- p0_rd_data  out  32  read data, valid when p0_ack, held until next port-0 completion
- p1_rd_req  in  1  load request pulse
- p1_wr_req  in  1  store request pulse
- p1_addr  in  32  byte address, sampled with a request
- p1_wr_data  in  32  store data, sampled with p1_wr_req
- p1_busy, p1_ack  out  1  as port 0
- p1_rd_data  out  32  as port 0; unchanged by write completions
- mem_rd_req, mem_wr_req  out  1  memory request pulses, exactly one cycle
- mem_addr, mem_wr_data  out  32  valid with the request pulse, held afterwards
- mem_busy  in  1  memory busy
- mem_ack  in  1  memory completion pulse
- mem_rd_data  in  32  valid with mem_ack
- proto_err  out  1  sticky: request while port busy, or p1_rd_req & p1_wr_req together
- timeout_err  out  1  sticky: WAIT exceeded TIMEOUT

## Operation
- Per-port holding register: {pending, is_wr, addr, wr_data}.
  - A request pulse while !pending captures the request, and pending=1 next cycle.
  - A request pulse while pending is dropped and sets proto_err.
  - p1 rd+wr in the same cycle: treated as a write, proto_err set.
- FSM states: IDLE, WAIT.
  - IDLE: if any port is pending and mem_busy==0, grant and register the memory request. mem_rd_req or mem_wr_req, mem_addr and mem_wr_data are driven the next cycle. Go to WAIT.
  - WAIT: request outputs are 0 and the timeout counter increments. On mem_ack: register the client ack and rd_data (reads only), clear that port's pending, update last_grant, return to IDLE.
- Round-robin: if both ports are pending, grant the port != last_grant; otherwise grant the single pending port. last_grant resets to 1, so port 0 wins the first tie.
- mem_ack seen in IDLE is ignored; it is a stray completion after reset.
- Counter saturates at TIMEOUT and sets timeout_err. The arbiter keeps waiting; it never abandons a transaction.
- Address and data pass through unmodified; the memory does its own word indexing.

## Timing
- Reset values: all outputs 0, both pending=0, state IDLE, last_grant=1, counter 0.
- Reset mid-transaction discards both holding registers and any outstanding grant. No client ack is produced for discarded requests.
- Client req pulse in cycle c: pN_busy=1 in c+1, and the memory request pulse is in c+2 if the arbiter is IDLE and memory is idle.
- With mem_ack in cycle m, the client ack and data are in m+1, pN_busy=0 in m+1, and IDLE is in m+1. The next grant's memory pulse can be no earlier than m+2.
- With the team memory (ack 6 cycles after its request cycle), end-to-end latency is client req in c to client ack in c+9.
- A client may issue its next request in its ack cycle; it is captured.
- A request arriving in the same cycle the other port is granted waits; it is granted on the next IDLE.
- Never more than one outstanding memory request.

## Test plan
- p0_rd_req at cycle 0, addr 0x10, memory word 4 = 0xCAFEF00D -> mem_rd_req only in cycle 2, p0_ack in cycle 9 with p0_rd_data 0xCAFEF00D.
- p1_wr_req addr 0x20 data 0x12345678, then p1_rd_req addr 0x20 in the ack cycle -> second ack returns 0x12345678; p1_rd_data is unchanged across the write ack.
- p0 and p1 requests in the same cycle, repeated 3 times -> grants ordered p0, p1, p0, p1, p0, p1; mem_req pulses never overlap.
- Second p0_rd_req while p0_busy -> dropped, proto_err=1 and stays 1, only one p0_ack.
- Memory model stalls ack for 70 cycles -> timeout_err=1 at WAIT cycle 64; the late ack still completes the client.
- rst low during WAIT, memory acks afterwards -> no client ack, outputs 0; a fresh request is then served normally.
